// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// instruction field codes and datapath mux select values.
package arm_ctrl_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  typedef enum logic [3:0] {
    FETCH    = S_FETCH,
    DECODE   = S_DECODE,
    MEMADR   = S_MEMADR,
    MEMRD    = S_MEMRD,
    MEMWB    = S_MEMWB,
    MEMWR    = S_MEMWR,
    EXECUTER = S_EXECUTER,
    EXECUTEI = S_EXECUTEI,
    ALUWB    = S_ALUWB,
    BRANCH   = S_BRANCH
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Commands outside the supported four fall back to add.
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: alu_decode = ALU_ADD;
      CMD_SUB: alu_decode = ALU_SUB;
      CMD_AND: alu_decode = ALU_AND;
      CMD_ORR: alu_decode = ALU_ORR;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields and ALU flags in, datapath controls out; master is the
// datapath side, slave is the controller.
interface multicycle_controller_if;

  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Illegal, State
  );

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Illegal, State
  );

endinterface

// File: rtl/multicycle_controller_cond_logic.sv
// NZCV flag register and ARM condition check; condex_q is captured once per
// instruction and gates both the flag writes and the controller's enables.
module cond_logic
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] INIT_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagWrite,
  input  logic       CondLoad,
  output logic       condex_q
);

  logic [3:0] flags_q, flags_d;
  logic       condex_d;
  logic       condex;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    condex = 1'b0;
    case (Cond)
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~c | z;
      COND_GE: condex = (n == v);
      COND_LT: condex = (n != v);
      COND_GT: condex = ~z & (n == v);
      COND_LE: condex = z | (n != v);
      COND_AL: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  // FlagWrite[1] covers N/Z, FlagWrite[0] covers C/V; a failed condition blocks both.
  always_comb begin
    flags_d  = flags_q;
    condex_d = condex_q;
    if (FlagWrite[1] && condex_q) flags_d[3:2] = ALUFlags[3:2];
    if (FlagWrite[0] && condex_q) flags_d[1:0] = ALUFlags[1:0];
    if (CondLoad) condex_d = condex;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q  <= INIT_FLAGS;
      condex_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main FSM and instruction decoder of the multicycle ARM-subset processor;
// every output is a function of the current state and the IR fields.
module multicycle_controller
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] INIT_FLAGS = 4'b0000
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_controller_if.slave ctrl
);

  state_e     state_q, state_d;
  logic       condex_q;
  logic [1:0] flag_write;
  logic       cond_load;
  logic [3:0] cmd;
  logic       cmd_arith;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic       alu_src_a, illegal;
  logic [1:0] result_src, alu_src_b, alu_control;

  assign cmd       = ctrl.Funct[4:1];
  assign cmd_arith = (cmd == CMD_ADD) || (cmd == CMD_SUB);

  cond_logic #(
    .INIT_FLAGS (INIT_FLAGS)
  ) u_cond (
    .clk       (clk),
    .reset     (reset),
    .Cond      (ctrl.Cond),
    .ALUFlags  (ctrl.ALUFlags),
    .FlagWrite (flag_write),
    .CondLoad  (cond_load),
    .condex_q  (condex_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = FETCH;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    flag_write  = 2'b00;
    cond_load   = 1'b0;

    case (state_q)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        pc_write   = 1'b1;
        state_d    = DECODE;
      end
      // PC already advanced by 4, so adding 4 again gives PC+8 for an R15 read.
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        cond_load  = 1'b1;
        case (ctrl.Op)
          OP_DP:   state_d = ctrl.Funct[5] ? EXECUTEI : EXECUTER;
          OP_MEM:  state_d = MEMADR;
          OP_BR:   state_d = BRANCH;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_b = SRCB_IMM;
        state_d   = ctrl.Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adr_src = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = condex_q;
      end
      MEMWR: begin
        adr_src   = 1'b1;
        mem_write = condex_q;
      end
      EXECUTER, EXECUTEI: begin
        alu_src_b   = (state_q == EXECUTEI) ? SRCB_IMM : SRCB_REG;
        alu_control = alu_decode(cmd);
        flag_write  = {ctrl.Funct[0], ctrl.Funct[0] & cmd_arith};
        state_d     = ALUWB;
      end
      ALUWB: begin
        reg_write = condex_q;
        pc_write  = condex_q & (ctrl.Rd == 4'd15);
      end
      BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_write   = condex_q;
      end
      default: state_d = FETCH;
    endcase
  end

  assign ctrl.PCWrite    = pc_write;
  assign ctrl.AdrSrc     = adr_src;
  assign ctrl.MemWrite   = mem_write;
  assign ctrl.IRWrite    = ir_write;
  assign ctrl.RegWrite   = reg_write;
  assign ctrl.ResultSrc  = result_src;
  assign ctrl.ALUSrcA    = alu_src_a;
  assign ctrl.ALUSrcB    = alu_src_b;
  assign ctrl.ALUControl = alu_control;
  assign ctrl.ImmSrc     = ctrl.Op;
  assign ctrl.RegSrc     = {ctrl.Op == OP_MEM, ctrl.Op == OP_BR};
  assign ctrl.Illegal    = illegal;
  assign ctrl.State      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: each instruction pushes its expected per-cycle control
// word, a negedge monitor pops and compares one word per clock.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] res;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluc;
    logic [1:0] imm;
    logic [1:0] regsrc;
    logic       ill;
  } exp_t;

  logic clk;
  logic reset;
  int   assert_count;
  int   fail_count;
  logic [3:0] flags_m;
  exp_t sb_q[$];

  multicycle_controller_if bus ();

  multicycle_controller #(
    .INIT_FLAGS (4'b0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus.slave)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, actual, expected);
    end
  endtask

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] exp_alu(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 2'b00;
      4'b0010: return 2'b01;
      4'b0000: return 2'b10;
      4'b1100: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic exp_t exp_cycle(input logic [3:0] st, input logic [1:0] op, input logic cx,
                                     input logic rd15, input logic [1:0] aluc);
    exp_t e;
    e        = '0;
    e.st     = st;
    e.imm    = op;
    e.regsrc = {op == 2'b01, op == 2'b10};
    case (st)
      4'd0: begin e.irw = 1; e.srca = 1; e.srcb = 2'b10; e.res = 2'b10; e.pcw = 1; end
      4'd1: begin e.srca = 1; e.srcb = 2'b10; e.res = 2'b10; e.ill = (op == 2'b11); end
      4'd2: e.srcb = 2'b01;
      4'd3: e.adr = 1;
      4'd4: begin e.res = 2'b01; e.regw = cx; end
      4'd5: begin e.adr = 1; e.memw = cx; end
      4'd6: e.aluc = aluc;
      4'd7: begin e.srcb = 2'b01; e.aluc = aluc; end
      4'd8: begin e.regw = cx; e.pcw = cx & rd15; end
      4'd9: begin e.srcb = 2'b01; e.res = 2'b10; e.pcw = cx; end
      default: ;
    endcase
    return e;
  endfunction

  // Drives one instruction, queues its expected cycles and runs up to max_cycles of it.
  task automatic applyStimulus(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                               input logic [3:0] rd, input logic [3:0] alu_flags, input int max_cycles);
    int   sts[$];
    logic cx;
    int   n;
    bus.Cond     = cond;
    bus.Op       = op;
    bus.Funct    = funct;
    bus.Rd       = rd;
    bus.ALUFlags = alu_flags;
    cx = cond_pass(cond, flags_m);
    sts = '{0, 1};
    case (op)
      2'b00: begin sts.push_back(funct[5] ? 7 : 6); sts.push_back(8); end
      2'b01: begin
        sts.push_back(2);
        if (funct[0]) begin sts.push_back(3); sts.push_back(4); end
        else sts.push_back(5);
      end
      2'b10: sts.push_back(9);
      default: ;
    endcase
    n = (sts.size() < max_cycles) ? sts.size() : max_cycles;
    for (int i = 0; i < n; i++)
      sb_q.push_back(exp_cycle(4'(sts[i]), op, cx, rd == 4'd15, exp_alu(funct[4:1])));
    if (op == 2'b00 && funct[0] && cx && n == sts.size()) begin
      flags_m[3:2] = alu_flags[3:2];
      if (funct[4:1] == 4'b0100 || funct[4:1] == 4'b0010) flags_m[1:0] = alu_flags[1:0];
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checkOutput("State",      32'(bus.State),      32'(e.st));
      checkOutput("PCWrite",    32'(bus.PCWrite),    32'(e.pcw));
      checkOutput("AdrSrc",     32'(bus.AdrSrc),     32'(e.adr));
      checkOutput("MemWrite",   32'(bus.MemWrite),   32'(e.memw));
      checkOutput("IRWrite",    32'(bus.IRWrite),    32'(e.irw));
      checkOutput("RegWrite",   32'(bus.RegWrite),   32'(e.regw));
      checkOutput("ResultSrc",  32'(bus.ResultSrc),  32'(e.res));
      checkOutput("ALUSrcA",    32'(bus.ALUSrcA),    32'(e.srca));
      checkOutput("ALUSrcB",    32'(bus.ALUSrcB),    32'(e.srcb));
      checkOutput("ALUControl", 32'(bus.ALUControl), 32'(e.aluc));
      checkOutput("ImmSrc",     32'(bus.ImmSrc),     32'(e.imm));
      checkOutput("RegSrc",     32'(bus.RegSrc),     32'(e.regsrc));
      checkOutput("Illegal",    32'(bus.Illegal),    32'(e.ill));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, fail_count %0d", fail_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    assert_count = 0;
    fail_count   = 0;
    flags_m      = 4'b0000;
    reset        = 1'b1;
    bus.Cond     = 4'hE;
    bus.Op       = 2'b00;
    bus.Funct    = 6'b000000;
    bus.Rd       = 4'd0;
    bus.ALUFlags = 4'b0000;

    #12;
    checkOutput("reset_State",    32'(bus.State),    32'd0);
    checkOutput("reset_PCWrite",  32'(bus.PCWrite),  32'd1);
    checkOutput("reset_IRWrite",  32'(bus.IRWrite),  32'd1);
    checkOutput("reset_MemWrite", 32'(bus.MemWrite), 32'd0);
    checkOutput("reset_RegWrite", 32'(bus.RegWrite), 32'd0);
    #10;
    reset = 1'b0;

    applyStimulus(4'hE, 2'b00, 6'b101000, 4'd1,  4'b0000, 99); // ADD imm
    applyStimulus(4'hE, 2'b01, 6'b011001, 4'd2,  4'b0000, 99); // LDR
    applyStimulus(4'hE, 2'b01, 6'b011000, 4'd2,  4'b0000, 99); // STR
    applyStimulus(4'hE, 2'b00, 6'b000101, 4'd3,  4'b0100, 99); // SUBS -> Z=1
    applyStimulus(4'h0, 2'b10, 6'b100000, 4'd0,  4'b0000, 99); // BEQ taken
    applyStimulus(4'h1, 2'b10, 6'b100000, 4'd0,  4'b0000, 99); // BNE not taken
    applyStimulus(4'hE, 2'b00, 6'b101001, 4'd4,  4'b0110, 99); // ADDS imm -> 0110
    applyStimulus(4'hE, 2'b00, 6'b000001, 4'd4,  4'b1001, 99); // ANDS -> 1010
    applyStimulus(4'h2, 2'b10, 6'b100000, 4'd0,  4'b0000, 99); // BCS taken
    applyStimulus(4'h6, 2'b10, 6'b100000, 4'd0,  4'b0000, 99); // BVS not taken
    applyStimulus(4'h4, 2'b10, 6'b100000, 4'd0,  4'b0000, 99); // BMI taken
    applyStimulus(4'h0, 2'b00, 6'b101001, 4'd5,  4'b0100, 99); // ADDEQS skipped
    applyStimulus(4'h0, 2'b10, 6'b100000, 4'd0,  4'b0000, 99); // BEQ not taken
    applyStimulus(4'hE, 2'b00, 6'b011000, 4'd15, 4'b0000, 99); // ORR to PC
    applyStimulus(4'hE, 2'b00, 6'b100100, 4'd6,  4'b0000, 99); // SUB imm
    applyStimulus(4'hE, 2'b00, 6'b011010, 4'd7,  4'b0000, 99); // MOV cmd -> add
    applyStimulus(4'hF, 2'b10, 6'b100000, 4'd0,  4'b0000, 99); // never
    applyStimulus(4'h0, 2'b01, 6'b011001, 4'd8,  4'b0000, 99); // LDREQ skipped
    applyStimulus(4'h0, 2'b01, 6'b011000, 4'd8,  4'b0000, 99); // STREQ skipped
    applyStimulus(4'hE, 2'b00, 6'b000101, 4'd3,  4'b0100, 99); // SUBS -> Z=1

    applyStimulus(4'hE, 2'b01, 6'b011000, 4'd2,  4'b0000, 3);  // STR up to MEMWR
    #1;
    checkOutput("memwr_State",    32'(bus.State),    32'd5);
    checkOutput("memwr_MemWrite", 32'(bus.MemWrite), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst_async_MemWrite", 32'(bus.MemWrite), 32'd0);
    checkOutput("rst_async_State",    32'(bus.State),    32'd0);
    checkOutput("rst_async_RegWrite", 32'(bus.RegWrite), 32'd0);
    flags_m = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus(4'hE, 2'b11, 6'b000000, 4'd0,  4'b0000, 99); // illegal
    applyStimulus(4'h0, 2'b10, 6'b100000, 4'd0,  4'b0000, 99); // BEQ, Z cleared
    applyStimulus(4'h1, 2'b10, 6'b100000, 4'd0,  4'b0000, 99); // BNE taken
    applyStimulus(4'hE, 2'b00, 6'b000000, 4'd9,  4'b0000, 99); // AND reg

    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
